aes_word_loader: RTL and testbench
==================================

AES_WORD_LOADER -- requirements
Module: aes_word_loader

Interface
REQ-001 SHALL have parameter CORE_LAT, default 41, meaning cycles from start pulse until the downstream core result is valid.
REQ-002 SHALL have parameter KEY_WORDS, default 4, meaning 32-bit key words per block; only 4 (AES-128) is supported.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port s_valid  input  1  upstream word valid.
REQ-006 SHALL have port s_ready  output  1  loader accepts word this cycle.
REQ-007 SHALL have port s_data  input  32  upstream word.
REQ-008 SHALL have port key_keep  input  1  sampled on first plaintext word; 1 = reuse stored key, skip key load.
REQ-009 SHALL have port clear  input  1  synchronous abort of the current job.
REQ-010 SHALL have port blk_in  output  128  plaintext to core.
REQ-011 SHALL have port blk_key  output  128  key to core.
REQ-012 SHALL have port start  output  1  one-cycle pulse to core.
REQ-013 SHALL have port busy  output  1  high from start pulse until blk_done.
REQ-014 SHALL have port blk_done  output  1  one-cycle pulse CORE_LAT cycles after start.

Function
REQ-015 SHALL implement states IDLE, LOAD_PT, LOAD_KEY, ISSUE, WAIT.
REQ-016 SHALL drive s_ready high only in IDLE, LOAD_PT and LOAD_KEY; a word transfers when s_valid and s_ready are both high.
REQ-017 SHALL, in IDLE, on transfer: store word into blk_in[127:96], latch key_keep, and go to LOAD_PT with word count 1.
REQ-018 SHALL, in LOAD_PT, store the nth word (n = 1..3) at blk_in[127-32n -: 32]; after word 3, go to ISSUE if latched key_keep = 1, else to LOAD_KEY.
REQ-019 SHALL, in LOAD_KEY, store key words MSB-first into blk_key in the same order; after the 4th word, go to ISSUE.
REQ-020 SHALL, in ISSUE, assert start for exactly one cycle, load the wait counter with CORE_LAT-1, and go to WAIT.
REQ-021 SHALL, in WAIT, decrement the counter each cycle; at zero, pulse blk_done for one cycle and return to IDLE.
REQ-022 SHALL hold blk_in and blk_key stable from ISSUE until blk_done.
REQ-023 SHALL keep s_ready low throughout ISSUE and WAIT; upstream words wait.
REQ-024 SHALL, when key_keep = 1 and no key has been loaded since reset, ignore key_keep and load the key.
REQ-025 SHALL, on clear in LOAD_PT or LOAD_KEY, discard the partial block, reset the word count, and go to IDLE; a word presented in the same cycle is not accepted (s_ready forced low).
REQ-026 SHALL ignore clear in ISSUE and WAIT; a started job always completes.
REQ-027 SHALL use a 2-bit word counter that wraps 3->0 on each state change; the wait counter width is clog2(CORE_LAT).
REQ-028 SHALL hold blk_key across jobs so that key_keep reuses it.

Reset
REQ-029 SHALL, on rst low, asynchronously go to IDLE and set blk_in = 0, blk_key = 0, start = 0, busy = 0, blk_done = 0, s_ready = 0, counters = 0, key-loaded flag = 0.
REQ-030 SHALL drive s_ready high from the first clock edge after rst deasserts; reset asserted mid-job aborts the job with no blk_done.

Structure
REQ-031 SHALL take the state encoding and the CORE_LAT default from a shared package aes_pkg, which the core also uses.
REQ-032 SHALL be a single module with no sub-modules; one registered FSM plus a combinational next-state block.

Verification
REQ-033 Send 8 words 00112233, 44556677, 8899aabb, ccddeeff, 00010203, 04050607, 08090a0b, 0c0d0e0f with key_keep = 0 -> blk_in = 00112233..eeff, blk_key = 000102..0f, and one start pulse one cycle after the 8th transfer; blk_done follows 41 cycles after start.
REQ-034 After REQ-033, send 4 plaintext words with key_keep = 1 -> exactly 4 transfers, blk_key unchanged, start pulse, blk_done at +41.
REQ-035 Hold s_valid high continuously for 16 words -> s_ready low for 42 cycles between jobs, no word lost or duplicated, two start pulses.
REQ-036 Assert clear after 5 words -> IDLE, no start; the next 8 words form a clean block.
REQ-037 Pull rst low in WAIT at counter 20 -> all outputs 0 immediately, no blk_done; key_keep on the next job forces a key load.
REQ-038 Assert key_keep = 1 on the first job after reset -> 8 words consumed (per REQ-024).

Source files
------------

// File: rtl/aes_pkg.sv
// Definitions shared by the AES word loader and the AES core it feeds.
package aes_pkg;

   localparam int AES_CORE_LAT = 41;
   localparam int AES_WORD_W   = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_PT,
      LOAD_KEY,
      ISSUE,
      WAIT
   } aes_state_e;

endpackage

// File: rtl/aes_word_loader.sv
// Collects 32-bit upstream words into a 128-bit plaintext block and key.
// Issues a start pulse to the AES core, then waits out the core latency.
module aes_word_loader
   import aes_pkg::*;
#(
   parameter int CORE_LAT  = AES_CORE_LAT,
   parameter int KEY_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [AES_WORD_W-1:0] s_data,
   input  logic                  key_keep,
   input  logic                  clear,
   output logic [127:0]          blk_in,
   output logic [127:0]          blk_key,
   output logic                  start,
   output logic                  busy,
   output logic                  blk_done
);

   localparam int              CntW        = $clog2(CORE_LAT);
   localparam logic [1:0]      LastKeyWord = 2'(KEY_WORDS - 1);
   localparam logic [CntW-1:0] WaitLoad    = CntW'(CORE_LAT - 1);

   aes_state_e      state_q, state_d;
   logic [1:0]      wordCnt_q, wordCnt_d;
   logic [CntW-1:0] waitCnt_q, waitCnt_d;
   logic            reuseKey_q, reuseKey_d;
   logic            keyLoaded_q, keyLoaded_d;
   logic [127:0]    blkIn_q, blkIn_d;
   logic [127:0]    blkKey_q, blkKey_d;
   logic            alive_q;
   logic [6:0]      slotLsb;

   // Word n of a group lands at bit 127-32n, i.e. slot (3-n) counting from the LSB.
   assign slotLsb = {~wordCnt_q, 5'b0};

   assign blk_in  = blkIn_q;
   assign blk_key = blkKey_q;

   // alive_q keeps s_ready low until the first clock edge after reset releases.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         wordCnt_q   <= '0;
         waitCnt_q   <= '0;
         reuseKey_q  <= 1'b0;
         keyLoaded_q <= 1'b0;
         blkIn_q     <= '0;
         blkKey_q    <= '0;
         alive_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         wordCnt_q   <= wordCnt_d;
         waitCnt_q   <= waitCnt_d;
         reuseKey_q  <= reuseKey_d;
         keyLoaded_q <= keyLoaded_d;
         blkIn_q     <= blkIn_d;
         blkKey_q    <= blkKey_d;
         alive_q     <= 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      wordCnt_d   = wordCnt_q;
      waitCnt_d   = waitCnt_q;
      reuseKey_d  = reuseKey_q;
      keyLoaded_d = keyLoaded_q;
      blkIn_d     = blkIn_q;
      blkKey_d    = blkKey_q;
      s_ready     = 1'b0;
      start       = 1'b0;
      busy        = 1'b0;
      blk_done    = 1'b0;

      case (state_q)
         IDLE: begin
            s_ready = alive_q;
            if (s_valid && alive_q) begin
               blkIn_d[slotLsb +: 32] = s_data;
               reuseKey_d             = key_keep && keyLoaded_q;
               wordCnt_d              = wordCnt_q + 2'd1;
               state_d                = LOAD_PT;
            end
         end

         LOAD_PT: begin
            if (clear) begin
               wordCnt_d = '0;
               state_d   = IDLE;
            end else begin
               s_ready = 1'b1;
               if (s_valid) begin
                  blkIn_d[slotLsb +: 32] = s_data;
                  wordCnt_d              = wordCnt_q + 2'd1;
                  if (wordCnt_q == 2'd3) begin
                     state_d = reuseKey_q ? ISSUE : LOAD_KEY;
                  end
               end
            end
         end

         LOAD_KEY: begin
            // An abort after key words were overwritten leaves no usable stored key.
            if (clear) begin
               if (wordCnt_q != 2'd0) begin
                  keyLoaded_d = 1'b0;
               end
               wordCnt_d = '0;
               state_d   = IDLE;
            end else begin
               s_ready = 1'b1;
               if (s_valid) begin
                  blkKey_d[slotLsb +: 32] = s_data;
                  wordCnt_d               = wordCnt_q + 2'd1;
                  if (wordCnt_q == LastKeyWord) begin
                     keyLoaded_d = 1'b1;
                     state_d     = ISSUE;
                  end
               end
            end
         end

         ISSUE: begin
            start     = 1'b1;
            busy      = 1'b1;
            waitCnt_d = WaitLoad;
            state_d   = WAIT;
         end

         WAIT: begin
            busy = 1'b1;
            if (waitCnt_q == '0) begin
               blk_done = 1'b1;
               state_d  = IDLE;
            end else begin
               waitCnt_d = waitCnt_q - CntW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_aes_word_loader.sv
// Self-checking bench for aes_word_loader: constant job table, hand-written
// corner sequences, and randomized traffic against a queue-based model.
module tb_aes_word_loader;

   localparam int CoreLat = 41;

   typedef struct packed {
      logic             keep;
      logic [0:3][31:0] pt;
      logic [0:3][31:0] key;
      logic [127:0]     expIn;
      logic [127:0]     expKey;
      logic [3:0]       expXfers;
   } jobVec_t;

   logic         clk, rst, s_valid, s_ready, key_keep, clear;
   logic         start, busy, blk_done;
   logic [31:0]  s_data;
   logic [127:0] blk_in, blk_key;

   int          nChecks = 0;
   int          nErrors = 0;
   logic [31:0] txQ[$];
   jobVec_t     jobs[5];
   jobVec_t     cleanJob;

   aes_word_loader #(
      .CORE_LAT (CoreLat),
      .KEY_WORDS(4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .key_keep(key_keep),
      .clear   (clear),
      .blk_in  (blk_in),
      .blk_key (blk_key),
      .start   (start),
      .busy    (busy),
      .blk_done(blk_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Reference model: words are gathered into a queue per job; a job completes
   // after 4 words when a stored key is reused, otherwise after 8.
   logic         alive;
   int           mCyc = 0;
   int           startDue = -1;
   int           doneDue = -1;
   bit           busyM = 0;
   bit           haveKey = 0;
   bit           reuse = 0;
   bit           expReady;
   logic [31:0]  mWords[$];
   logic [127:0] mKey = '0;
   logic [127:0] expIn = '0;
   logic [127:0] expKey = '0;

   always @(posedge clk or negedge rst) begin
      if (!rst) alive <= 1'b0;
      else      alive <= 1'b1;
   end

   always @(negedge clk) begin
      mCyc++;
      if (!rst) begin
         busyM = 0; haveKey = 0; reuse = 0; startDue = -1; doneDue = -1;
         mWords.delete();
         checkOutput("rst.s_ready", s_ready, 0);
         checkOutput("rst.start", start, 0);
         checkOutput("rst.busy", busy, 0);
         checkOutput("rst.blk_done", blk_done, 0);
         checkOutput("rst.blk_in", blk_in, 0);
         checkOutput("rst.blk_key", blk_key, 0);
      end else begin
         expReady = alive && !busyM && !(clear && mWords.size() > 0);
         checkOutput("model.s_ready", s_ready, expReady);
         checkOutput("model.start", start, mCyc == startDue);
         checkOutput("model.blk_done", blk_done, mCyc == doneDue);
         checkOutput("model.busy", busy, busyM);
         if (mCyc == startDue || mCyc == doneDue) begin
            checkOutput("model.blk_in", blk_in, expIn);
            checkOutput("model.blk_key", blk_key, expKey);
         end
         if (busyM) begin
            if (mCyc == doneDue) busyM = 0;
         end else if (clear && mWords.size() > 0) begin
            if (!reuse && mWords.size() > 4) haveKey = 0;
            mWords.delete();
         end else if (s_valid && expReady) begin
            if (mWords.size() == 0) reuse = key_keep && haveKey;
            mWords.push_back(s_data);
            if (mWords.size() == (reuse ? 4 : 8)) begin
               expIn = {mWords[0], mWords[1], mWords[2], mWords[3]};
               if (reuse) expKey = mKey;
               else       expKey = {mWords[4], mWords[5], mWords[6], mWords[7]};
               mKey     = expKey;
               haveKey  = 1;
               busyM    = 1;
               startDue = mCyc + 1;
               doneDue  = mCyc + 1 + CoreLat;
               mWords.delete();
            end
         end
      end
   end

   // Presents plaintext then key words until a start pulse appears.
   task automatic runJob(input jobVec_t v, input string tag);
      int           idx, xfers, cyc, lastXfer, startCyc, doneLat;
      bit           started, done;
      logic [127:0] inAtStart, keyAtStart;
      idx = 0; xfers = 0; cyc = 0; lastXfer = -100; startCyc = 0; doneLat = 0;
      started = 0; done = 0; inAtStart = '0; keyAtStart = '0;
      key_keep = v.keep;
      while (!started && cyc < 200) begin
         s_valid = (idx < 8);
         if (idx < 4)      s_data = v.pt[idx];
         else if (idx < 8) s_data = v.key[idx-4];
         else              s_data = 32'h0;
         @(negedge clk);
         if (start) begin
            started = 1; startCyc = cyc; inAtStart = blk_in; keyAtStart = blk_key;
         end else if (s_valid && s_ready) begin
            idx++; xfers++; lastXfer = cyc;
         end
         @(posedge clk); #1;
         cyc++;
      end
      s_valid = 1'b0;
      checkOutput({tag, ".started"}, started, 1);
      checkOutput({tag, ".xfers"}, xfers, v.expXfers);
      checkOutput({tag, ".startGap"}, startCyc - lastXfer, 1);
      checkOutput({tag, ".blk_in"}, inAtStart, v.expIn);
      checkOutput({tag, ".blk_key"}, keyAtStart, v.expKey);
      cyc = 0;
      while (!done && cyc < 100) begin
         @(negedge clk);
         if (blk_done) begin
            done = 1; doneLat = cyc + 1;
            checkOutput({tag, ".inHeld"}, blk_in, v.expIn);
            checkOutput({tag, ".keyHeld"}, blk_key, v.expKey);
         end
         @(posedge clk); #1;
         cyc++;
      end
      checkOutput({tag, ".doneLat"}, doneLat, CoreLat);
   endtask

   // Presents txQ words in order until n have been accepted.
   task automatic applyStimulus(input int n, input bit keep, output int accepted);
      int cyc;
      cyc = 0; accepted = 0;
      key_keep = keep;
      while (accepted < n && cyc < 200) begin
         s_valid = 1'b1;
         s_data  = txQ[accepted];
         @(negedge clk);
         if (s_ready) accepted++;
         @(posedge clk); #1;
         cyc++;
      end
      s_valid = 1'b0;
   endtask

   // Holds s_valid high across all txQ words and waits for expDones completions.
   task automatic streamWords(input int expDones, output int xfers, output int starts,
                              output int dones, output int maxLow);
      int cyc, low;
      cyc = 0; low = 0; xfers = 0; starts = 0; dones = 0; maxLow = 0;
      key_keep = 1'b0;
      while ((xfers < txQ.size() || dones < expDones) && cyc < 400) begin
         s_valid = (xfers < txQ.size());
         s_data  = s_valid ? txQ[xfers] : 32'h0;
         @(negedge clk);
         if (start) starts++;
         if (blk_done) dones++;
         if (s_valid && s_ready) xfers++;
         if (!s_ready) begin
            low++;
         end else begin
            if (low > maxLow) maxLow = low;
            low = 0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      s_valid = 1'b0;
   endtask

   initial begin
      #500000;
      nErrors++;
      $display("[TB] FAIL watchdog: got timeout, expected run to complete");
      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acc, xfers, starts, dones, maxLow, rDones;
      bit found;

      jobs[0] = '{keep: 1'b1,
                  pt: {32'ha0a1a2a3, 32'hb0b1b2b3, 32'hc0c1c2c3, 32'hd0d1d2d3},
                  key: {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444},
                  expIn: 128'ha0a1a2a3_b0b1b2b3_c0c1c2c3_d0d1d2d3,
                  expKey: 128'h11111111_22222222_33333333_44444444,
                  expXfers: 4'd8};
      jobs[1] = '{keep: 1'b0,
                  pt: {32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff},
                  key: {32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f},
                  expIn: 128'h00112233_44556677_8899aabb_ccddeeff,
                  expKey: 128'h00010203_04050607_08090a0b_0c0d0e0f,
                  expXfers: 4'd8};
      jobs[2] = '{keep: 1'b1,
                  pt: {32'hdeadbeef, 32'hcafef00d, 32'h12345678, 32'h9abcdef0},
                  key: {32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff},
                  expIn: 128'hdeadbeef_cafef00d_12345678_9abcdef0,
                  expKey: 128'h00010203_04050607_08090a0b_0c0d0e0f,
                  expXfers: 4'd4};
      jobs[3] = '{keep: 1'b0,
                  pt: {32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210},
                  key: {32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100},
                  expIn: 128'h01234567_89abcdef_fedcba98_76543210,
                  expKey: 128'h0f0e0d0c_0b0a0908_07060504_03020100,
                  expXfers: 4'd8};
      jobs[4] = '{keep: 1'b1,
                  pt: {32'h5a5a5a5a, 32'ha5a5a5a5, 32'h3c3c3c3c, 32'hc3c3c3c3},
                  key: {32'heeeeeeee, 32'heeeeeeee, 32'heeeeeeee, 32'heeeeeeee},
                  expIn: 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3,
                  expKey: 128'h0f0e0d0c_0b0a0908_07060504_03020100,
                  expXfers: 4'd4};
      cleanJob = '{keep: 1'b0,
                   pt: {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444},
                   key: {32'h13579bdf, 32'h2468ace0, 32'h0badf00d, 32'hfeedface},
                   expIn: 128'h77777777_66666666_55555555_44444444,
                   expKey: 128'h13579bdf_2468ace0_0badf00d_feedface,
                   expXfers: 4'd8};

      rst = 1'b1; s_valid = 1'b0; s_data = '0; key_keep = 1'b0; clear = 1'b0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 5; i++) begin
         runJob(jobs[i], $sformatf("job%0d", i));
      end

      txQ.delete();
      for (int i = 0; i < 16; i++) txQ.push_back(32'h10000000 + 32'(i) * 32'h01010101);
      streamWords(2, xfers, starts, dones, maxLow);
      checkOutput("stream.xfers", xfers, 16);
      checkOutput("stream.starts", starts, 2);
      checkOutput("stream.dones", dones, 2);
      checkOutput("stream.readyLowRun", maxLow, CoreLat + 1);

      txQ.delete();
      for (int i = 0; i < 5; i++) txQ.push_back(32'hc1ea0000 + 32'(i));
      applyStimulus(5, 1'b0, acc);
      checkOutput("clear.accepted", acc, 5);
      clear = 1'b1; s_valid = 1'b1; s_data = 32'hbad0bad0;
      @(negedge clk);
      checkOutput("clear.s_ready", s_ready, 0);
      @(posedge clk); #1;
      clear = 1'b0; s_valid = 1'b0;
      starts = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (start) starts++;
         @(posedge clk); #1;
      end
      checkOutput("clear.noStart", starts, 0);
      runJob(cleanJob, "afterClear");

      txQ.delete();
      for (int i = 0; i < 4; i++) txQ.push_back(jobs[1].pt[i]);
      for (int i = 0; i < 4; i++) txQ.push_back(jobs[1].key[i]);
      applyStimulus(8, 1'b0, acc);
      checkOutput("rstJob.accepted", acc, 8);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         found = start;
      end
      checkOutput("rstJob.start", found, 1);
      repeat (21) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      checkOutput("midRst.s_ready", s_ready, 0);
      checkOutput("midRst.busy", busy, 0);
      checkOutput("midRst.start", start, 0);
      checkOutput("midRst.blk_done", blk_done, 0);
      checkOutput("midRst.blk_in", blk_in, 0);
      checkOutput("midRst.blk_key", blk_key, 0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      dones = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (blk_done) dones++;
         @(posedge clk); #1;
      end
      checkOutput("midRst.noDone", dones, 0);
      runJob(jobs[0], "keepAfterRst");

      rDones = 0;
      for (int i = 0; i < 1500; i++) begin
         s_valid  = ($urandom_range(3) != 0);
         s_data   = $urandom;
         key_keep = 1'($urandom_range(1));
         clear    = ($urandom_range(39) == 0);
         @(negedge clk);
         if (blk_done) rDones++;
         @(posedge clk); #1;
      end
      s_valid = 1'b0; clear = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (blk_done) rDones++;
         @(posedge clk); #1;
      end
      checkOutput("random.jobsCompleted", rDones >= 5, 1);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
